data_mem_resp: RTL and testbench
================================

DATA_MEM_RESP -- requirements
Module: data_mem_resp

Interface
REQ-001 SHALL provide parameter ADDR_W, default 8, meaning word-address width; storage depth = 2**ADDR_W 32-bit words.
REQ-002 SHALL provide port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL provide port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL provide port writeIn  input  1  request type: 1 = write, 0 = read; sampled only on request acceptance.
REQ-005 SHALL provide port reqValid  input  1  initiator presents a request.
REQ-006 SHALL provide port reqReady  output  1  block can accept a request this cycle.
REQ-007 SHALL provide port addressIn  input  32  byte address of request.
REQ-008 SHALL provide port dataIn  input  32  write data.
REQ-009 SHALL provide port respValid  output  1  response presented.
REQ-010 SHALL provide port respReady  input  1  initiator accepts response.
REQ-011 SHALL provide port dataOut  output  32  read data; 0 for write responses and error responses.
REQ-012 SHALL provide port respErr  output  1  request was rejected (misaligned or out of range); qualified by respValid.

Function
REQ-013 SHALL accept a request on a rising edge where reqValid && reqReady; writeIn, addressIn, dataIn captured into request registers on that edge.
REQ-014 SHALL implement FSM states IDLE, ACCESS, RESP; reqReady = 1 only in IDLE; one outstanding request maximum.
REQ-015 IDLE: on acceptance -> ACCESS; otherwise remain IDLE.
REQ-016 ACCESS (exactly one cycle): perform storage operation, -> RESP.
REQ-017 RESP: respValid = 1; on respReady -> IDLE; otherwise hold RESP with dataOut and respErr stable.
REQ-018 Word index = captured addressIn[ADDR_W+1:2].
REQ-019 Error when captured addressIn[1:0] != 0 or addressIn[31:ADDR_W+2] != 0; on error: no storage write, respErr = 1, dataOut = 0.
REQ-020 Valid write: storage[index] <= captured data on the ACCESS edge; response respErr = 0, dataOut = 0.
REQ-021 Valid read: dataOut = storage[index] as of the ACCESS cycle, registered; respErr = 0.
REQ-022 Latency: request accepted at edge N -> respValid high after edge N+2; earliest next acceptance at the edge after respValid&&respReady handshake edge (back-to-back throughput = 1 request per 3 cycles).
REQ-023 reqValid/addressIn/dataIn/writeIn changes while not in IDLE SHALL have no effect.
REQ-024 respReady while not in RESP SHALL be ignored.
REQ-025 A read following a write to the same index SHALL return the newly written data.
REQ-026 Storage SHALL be inferable as a single-port synchronous RAM (one access per cycle, in ACCESS only).

Reset
REQ-027 rst low SHALL immediately force state IDLE, reqReady = 1 after release, respValid = 0, respErr = 0, dataOut = 0, request registers = 0.
REQ-028 Storage contents SHALL NOT be reset; reads of never-written words return undefined data.
REQ-029 Reset asserted in ACCESS SHALL abort the request: write in progress either completes fully or not at all, no response issued after reset release.
REQ-030 First acceptance after reset release SHALL be possible on the first rising edge with rst high.

Verification
REQ-031 Write addr 0x0000_0010 data 0xDEAD_BEEF, then read 0x10 -> write resp respErr=0 dataOut=0; read resp dataOut=0xDEAD_BEEF, respValid 2 cycles after acceptance.
REQ-032 Read addr 0x0000_0013 (misaligned) and, with ADDR_W=8, write addr 0x0000_0400 -> respErr=1, dataOut=0; subsequent read of 0x0 unchanged by the rejected write.
REQ-033 Read with respReady held low 5 cycles -> respValid and dataOut stable 5 cycles, reqReady=0 throughout, reqValid pulses ignored; respReady=1 -> IDLE next edge.
REQ-034 Back-to-back writes 0x0,0x4,0x8 with reqValid held high and respReady=1 -> acceptances every 3 cycles, reads return written values in order.
REQ-035 Assert rst during ACCESS of a read -> respValid=0, dataOut=0 immediately; after release reqReady=1 and no stale response appears.
REQ-036 Write 0xFFFF_FFFF to index 255 (addr 0x3FC, ADDR_W=8), read 0x3FC -> 0xFFFF_FFFF, respErr=0 (top-of-range boundary).

Source files
------------

// File: rtl/data_mem_resp.sv
// data_mem_resp: single-outstanding request/response front end for a word-addressed 32-bit RAM
// Ports:
//   clk, rst (async, active-low)
//   request  : reqValid/reqReady handshake, writeIn, addressIn (byte address), dataIn
//   response : respValid/respReady handshake, dataOut (read data, else 0), respErr
// Flow: IDLE accepts, ACCESS performs the single RAM access, RESP holds until respReady.
module data_mem_resp #(
  parameter int ADDR_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        writeIn,
  input  logic        reqValid,
  output logic        reqReady,
  input  logic [31:0] addressIn,
  input  logic [31:0] dataIn,
  output logic        respValid,
  input  logic        respReady,
  output logic [31:0] dataOut,
  output logic        respErr
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t state, state_nxt;
  logic        wr_q;
  logic [31:0] addr_q, data_q, ram_q;
  logic [31:0] mem [2**ADDR_W];
  logic [ADDR_W-1:0] idx;
  logic err;
  assign idx = addr_q[ADDR_W+1:2];
  // misaligned or beyond the implemented depth
  assign err = (|addr_q[1:0]) || (|addr_q[31:ADDR_W+2]);
  always_comb begin
    state_nxt = state;
    reqReady  = 1'b0;
    respValid = 1'b0;
    respErr   = 1'b0;
    dataOut   = '0;
    state_nxt = state == IDLE   ? (reqValid ? ACCESS : IDLE) :
                state == ACCESS ? RESP :
                                  (respReady ? IDLE : RESP);
    reqReady  = state == IDLE;
    respValid = state == RESP;
    respErr   = respValid && err;
    // ram_q is only meaningful for a valid read; everything else reports zero
    dataOut   = (respValid && !err && !wr_q) ? ram_q : '0;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      wr_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      state <= state_nxt;
      if (reqValid && reqReady) begin
        wr_q   <= writeIn;
        addr_q <= addressIn;
        data_q <= dataIn;
      end
    end
  end
  // Single-port RAM, unreset; reset forces state out of ACCESS so an aborted access never lands.
  always_ff @(posedge clk) begin
    if (state == ACCESS) begin
      if (wr_q && !err) mem[idx] <= data_q;
      ram_q <= mem[idx];
    end
  end
endmodule

// File: tb/tb_data_mem_resp.sv
// tb_data_mem_resp: randomized + directed check of data_mem_resp against a transaction-level model
module tb_data_mem_resp;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        writeIn = 1'b0;
  logic        reqValid = 1'b0;
  logic        reqReady;
  logic [31:0] addressIn = '0;
  logic [31:0] dataIn = '0;
  logic        respValid;
  logic        respReady = 1'b0;
  logic [31:0] dataOut;
  logic        respErr;
  int compared = 0;
  int mismatched = 0;
  int cyc = 0;

  data_mem_resp #(.ADDR_W(8)) dut (
    .clk(clk), .rst(rst), .writeIn(writeIn), .reqValid(reqValid), .reqReady(reqReady),
    .addressIn(addressIn), .dataIn(dataIn), .respValid(respValid), .respReady(respReady),
    .dataOut(dataOut), .respErr(respErr)
  );

  always #5 clk = ~clk;

  // Transaction model: one pending request, aged in cycles since acceptance.
  bit          busy = 0;
  bit          age = 0;
  bit          m_wr = 0;
  bit          m_err = 0;
  bit          m_known = 0;
  logic [31:0] m_a = '0;
  logic [31:0] m_d = '0;
  logic [31:0] m_rdata = '0;
  logic [31:0] mem_m [256];
  bit          known [256];

  function automatic bit bad_addr(input logic [31:0] a);
    return (a % 4 != 0) || (a >= 32'd1024);
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy <= 0;
    end else if (!busy) begin
      if (reqValid) begin
        busy  <= 1;
        age   <= 0;
        m_wr  <= writeIn;
        m_a   <= addressIn;
        m_d   <= dataIn;
        m_err <= bad_addr(addressIn);
      end
    end else if (!age) begin
      age <= 1;
      if (!m_err) begin
        if (m_wr) begin
          mem_m[(m_a / 4) % 256] <= m_d;
          known[(m_a / 4) % 256] <= 1;
        end else begin
          m_rdata <= mem_m[(m_a / 4) % 256];
          m_known <= known[(m_a / 4) % 256];
        end
      end
    end else if (respReady) begin
      busy <= 0;
    end
  end

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s @cyc %0d: got %h expected %h", n, cyc, act, exp);
    end
  endtask

  task automatic check_model();
    bit rv;
    rv = busy && age;
    chk("reqReady", {31'd0, reqReady}, {31'd0, !busy});
    chk("respValid", {31'd0, respValid}, {31'd0, rv});
    chk("respErr", {31'd0, respErr}, {31'd0, rv && m_err});
    if (!(rv && !m_err && !m_wr && !m_known))
      chk("dataOut", dataOut, (rv && !m_err && !m_wr) ? m_rdata : 32'd0);
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    check_model();
  endtask

  // Issues one request from IDLE with respReady high; returns the response seen.
  task automatic req(input bit w, input logic [31:0] a, input logic [31:0] d,
                     output logic [31:0] dout, output logic e);
    reqValid = 1; writeIn = w; addressIn = a; dataIn = d; respReady = 1;
    step();
    reqValid = 1'($urandom); writeIn = 1'($urandom); addressIn = $urandom; dataIn = $urandom;
    step();
    chk("lat_respValid", {31'd0, respValid}, 32'd1);
    dout = dataOut;
    e = respErr;
    reqValid = 0;
    step();
    chk("post_reqReady", {31'd0, reqReady}, 32'd1);
  endtask

  initial begin
    logic [31:0] d;
    logic e;
    logic [31:0] v [3];
    int k, last;
    repeat (2) step();
    chk("rst_respValid", {31'd0, respValid}, 32'd0);
    chk("rst_dataOut", dataOut, 32'd0);
    chk("rst_respErr", {31'd0, respErr}, 32'd0);
    rst = 1;
    req(1, 32'h10, 32'hDEADBEEF, d, e);
    chk("w10_err", {31'd0, e}, 32'd0);
    chk("w10_data", d, 32'd0);
    req(0, 32'h10, 32'h0, d, e);
    chk("r10_data", d, 32'hDEADBEEF);
    chk("r10_err", {31'd0, e}, 32'd0);
    req(1, 32'h0, 32'h12345678, d, e);
    req(0, 32'h13, 32'h0, d, e);
    chk("mis_err", {31'd0, e}, 32'd1);
    chk("mis_data", d, 32'd0);
    req(1, 32'h400, 32'hBADBAD00, d, e);
    chk("oor_err", {31'd0, e}, 32'd1);
    chk("oor_data", d, 32'd0);
    req(0, 32'h0, 32'h0, d, e);
    chk("r0_unchanged", d, 32'h12345678);
    req(1, 32'h3FC, 32'hFFFFFFFF, d, e);
    req(0, 32'h3FC, 32'h0, d, e);
    chk("top_data", d, 32'hFFFFFFFF);
    chk("top_err", {31'd0, e}, 32'd0);
    // response held while respReady stays low
    req(1, 32'h20, 32'hA5A5_0F0F, d, e);
    reqValid = 1; writeIn = 0; addressIn = 32'h20; respReady = 0;
    step();
    step();
    for (int i = 0; i < 5; i++) begin
      chk("hold_respValid", {31'd0, respValid}, 32'd1);
      chk("hold_dataOut", dataOut, 32'hA5A5_0F0F);
      chk("hold_reqReady", {31'd0, reqReady}, 32'd0);
      reqValid = 1'($urandom); writeIn = 1'($urandom); addressIn = $urandom; dataIn = $urandom;
      step();
    end
    respReady = 1;
    step();
    reqValid = 0;
    chk("hold_release", {31'd0, reqReady}, 32'd1);
    // back-to-back writes, reqValid held high
    v[0] = 32'h1111_0000; v[1] = 32'h2222_0004; v[2] = 32'h3333_0008;
    reqValid = 1; writeIn = 1; respReady = 1; k = 0; last = 0;
    for (int c = 0; c < 15 && k < 3; c++) begin
      if (reqReady) begin
        addressIn = 32'(k * 4);
        dataIn = v[k];
        if (k > 0) chk("b2b_spacing", 32'(cyc - last), 32'd3);
        last = cyc;
        k++;
      end
      step();
    end
    if (k < 3) chk("b2b_timeout", 32'(k), 32'd3);
    reqValid = 0;
    step();
    step();
    for (int i = 0; i < 3; i++) begin
      req(0, 32'(i * 4), 32'h0, d, e);
      chk("b2b_read", d, v[i]);
    end
    // reset during ACCESS of a read
    reqValid = 1; writeIn = 0; addressIn = 32'h10;
    step();
    reqValid = 0;
    rst = 0;
    #1;
    chk("abort_respValid", {31'd0, respValid}, 32'd0);
    chk("abort_dataOut", dataOut, 32'd0);
    step();
    rst = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("abort_no_resp", {31'd0, respValid}, 32'd0);
    end
    chk("abort_reqReady", {31'd0, reqReady}, 32'd1);
    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      int r;
      r = int'($urandom_range(0, 9));
      rst = ($urandom_range(0, 59) != 0);
      reqValid = 1'($urandom);
      writeIn = 1'($urandom);
      dataIn = $urandom;
      respReady = ($urandom_range(0, 3) != 0);
      addressIn = r < 7 ? 32'($urandom_range(0, 15) * 4) :
                  r == 7 ? (32'($urandom_range(0, 15) * 4) | 32'($urandom_range(1, 3))) :
                  r == 8 ? ($urandom | 32'h400) : $urandom;
      step();
    end
    rst = 1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
